// File: rtl/div_restoring_4bit.sv
// Unsigned restoring divider: one trial subtraction per clock, done pulses WIDTH+1 cycles after start; start ignored while busy.
// Optional DIV_ZERO_CHK_EN: divisor==0 skips iteration (done next cycle, div_by_zero=1); otherwise div_by_zero is tied 0.
module div_restoring_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [CW-1:0]    count;
   logic             accept;
   logic             zero_skip;
   logic [WIDTH:0]   s;
   logic [WIDTH:0]   t;
   logic             no_borrow;
   logic [WIDTH-1:0] p_step;
   logic [WIDTH-1:0] q_step;

   assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef DIV_ZERO_CHK_EN
   assign zero_skip = (divisor == '0);
`else
   assign zero_skip = 1'b0;
`endif

   // Partial remainder stays below the divisor, so WIDTH bits hold it;
   // the extra bit only exists in the trial difference to expose the borrow.
   assign s         = {p, q[WIDTH-1]};
   assign t         = s + ~{1'b0, d} + {{WIDTH{1'b0}}, 1'b1};
   assign no_borrow = ~t[WIDTH];
   assign p_step    = no_borrow ? t[WIDTH-1:0] : s[WIDTH-1:0];
   assign q_step    = {q[WIDTH-2:0], no_borrow};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = zero_skip ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (count == '0) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (accept) state_nxt = zero_skip ? DONE : RUN;
            else        state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p         <= '0;
         q         <= '0;
         d         <= '0;
         count     <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (accept) begin
         p     <= '0;
         q     <= dividend;
         d     <= divisor;
         count <= CW'(WIDTH - 1);
         if (zero_skip) begin
            quotient  <= '1;
            remainder <= dividend;
         end
      end else if (state == RUN) begin
         p <= p_step;
         q <= q_step;
         if (count != '0) begin
            count <= count - CW'(1);
         end else begin
            quotient  <= q_step;
            remainder <= p_step;
         end
      end
   end

`ifdef DIV_ZERO_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_by_zero <= 1'b0;
      end else if (accept) begin
         div_by_zero <= zero_skip;
      end
   end
`else
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_restoring_4bit.sv
// Randomized and directed bench for div_restoring_4bit against an arithmetic reference.
module tb_div_restoring_4bit;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;

   div_restoring_4bit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_q(input int a, input int b);
      return (b == 0) ? (1 << W) - 1 : a / b;
   endfunction

   function automatic int ref_r(input int a, input int b);
      return (b == 0) ? a : a % b;
   endfunction

   function automatic int ref_lat(input int b);
`ifdef DIV_ZERO_CHK_EN
      return (b == 0) ? 1 : W + 1;
`else
      return W + 1;
`endif
   endfunction

   function automatic int ref_dbz(input int b);
`ifdef DIV_ZERO_CHK_EN
      return (b == 0) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   // Called one time unit after an edge; returns in cycle 1 of the operation.
   task automatic launch(input int a, input int b);
      start    = 1'b1;
      dividend = W'(a);
      divisor  = W'(b);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Walks cycles until done; returns inside the done cycle with start low.
   task automatic wait_done(input int a, input int b, input int first_cyc, input bit noise);
      int cyc = first_cyc;
      bit busy_bad = 1'b0;
      while (done !== 1'b1 && cyc <= 3 * W + 4) begin
         if (busy !== 1'b1) busy_bad = 1'b1;
         if (noise) begin
            start    = 1'($urandom_range(0, 1));
            dividend = W'($urandom);
            divisor  = W'($urandom);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
      check($sformatf("latency %0d/%0d", a, b), cyc, ref_lat(b));
      check($sformatf("busy_run %0d/%0d", a, b), busy_bad, 0);
      check($sformatf("busy_with_done %0d/%0d", a, b), busy & done, 0);
      check($sformatf("quotient %0d/%0d", a, b), quotient, ref_q(a, b));
      check($sformatf("remainder %0d/%0d", a, b), remainder, ref_r(a, b));
      check($sformatf("div_by_zero %0d/%0d", a, b), div_by_zero, ref_dbz(b));
   endtask

   task automatic no_extra(input int n);
      bit seen = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen = 1'b1;
      end
      check("no_extra_done", seen, 0);
   endtask

   initial begin
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      launch(13, 4); wait_done(13, 4, 1, 1'b0); no_extra(6);
      launch(15, 1); wait_done(15, 1, 1, 1'b0); no_extra(2);
      launch(7, 9);  wait_done(7, 9, 1, 1'b0);  no_extra(2);
      launch(9, 0);  wait_done(9, 0, 1, 1'b0);  no_extra(2);
      launch(5, 3);  wait_done(5, 3, 1, 1'b0);  no_extra(2);

      // Start pulses during the run must be ignored.
      launch(12, 5);
      @(posedge clk); #1;
      start = 1'b1; dividend = 4'd3; divisor = 4'd1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(12, 5, 4, 1'b0);
      no_extra(8);

      // Back-to-back accept in the done cycle.
      launch(14, 3); wait_done(14, 3, 1, 1'b0);
      launch(8, 2);  wait_done(8, 2, 1, 1'b0);
      no_extra(3);

      // Reset in the middle of a run.
      launch(11, 2);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_quotient", quotient, 0);
      check("midrst_remainder", remainder, 0);
      check("midrst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      no_extra(10);
      launch(11, 2); wait_done(11, 2, 1, 1'b0);
      no_extra(1);

      for (int a = 0; a < (1 << W); a++) begin
         for (int b = 0; b < (1 << W); b++) begin
            launch(a, b);
            wait_done(a, b, 1, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
               @(posedge clk); #1;
            end
         end
      end

      for (int i = 0; i < 80; i++) begin
         int a = int'($urandom_range(0, (1 << W) - 1));
         int b = int'($urandom_range(0, (1 << W) - 1));
         launch(a, b);
         wait_done(a, b, 1, 1'b1);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
